// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants, derived totals and sync window bounds
// shared by the VGA timing generator and its counters.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam logic [CNT_W-1:0] DEF_H_VISIBLE = 11'd640;
  localparam logic [CNT_W-1:0] DEF_H_FP      = 11'd16;
  localparam logic [CNT_W-1:0] DEF_H_SYNC    = 11'd96;
  localparam logic [CNT_W-1:0] DEF_H_BP      = 11'd48;
  localparam logic [CNT_W-1:0] DEF_V_VISIBLE = 11'd480;
  localparam logic [CNT_W-1:0] DEF_V_FP      = 11'd10;
  localparam logic [CNT_W-1:0] DEF_V_SYNC    = 11'd2;
  localparam logic [CNT_W-1:0] DEF_V_BP      = 11'd33;
  localparam logic             DEF_SYNC_POL  = 1'b0;

  localparam logic [CNT_W-1:0] DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam logic [CNT_W-1:0] DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [CNT_W-1:0] DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam logic [CNT_W-1:0] DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 11'd1;
  localparam logic [CNT_W-1:0] DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam logic [CNT_W-1:0] DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 11'd1;

  // Inclusive unsigned window test used for both sync pulses.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-(MAX+1) counter that advances on en and reports its next value and
// a wrap strobe, so the caller can decode flags aligned with the new count.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX = 11'd799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             wrap
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  always_comb begin
    w_at_max   = (r_count == MAX);
    wrap       = en & w_at_max;
    count_next = r_count;
    if (en) begin
      count_next = w_at_max ? '0 : r_count + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= count_next;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel coordinates plus blank/sync/frame_start, all
// registered and decoded from the next count so flags line up with the counts.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_VISIBLE = DEF_H_VISIBLE,
  parameter logic [CNT_W-1:0] H_FP      = DEF_H_FP,
  parameter logic [CNT_W-1:0] H_SYNC    = DEF_H_SYNC,
  parameter logic [CNT_W-1:0] H_BP      = DEF_H_BP,
  parameter logic [CNT_W-1:0] V_VISIBLE = DEF_V_VISIBLE,
  parameter logic [CNT_W-1:0] V_FP      = DEF_V_FP,
  parameter logic [CNT_W-1:0] V_SYNC    = DEF_V_SYNC,
  parameter logic [CNT_W-1:0] V_BP      = DEF_V_BP,
  parameter logic             SYNC_POL  = DEF_SYNC_POL
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             blank,
  output logic             hSync,
  output logic             vSync,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 11'd1;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 11'd1;

  logic [CNT_W-1:0] w_h_count;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_count;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_v_en;
  logic             w_blank_next;
  logic             w_hsync_next;
  logic             w_vsync_next;

  logic r_blank;
  logic r_hsync;
  logic r_vsync;
  logic r_frame_start;

  assign w_v_en = ce & w_h_wrap;

  mod_counter #(.MAX(H_TOTAL - 11'd1)) u_h_cnt (
    .clk        (pixel_clk),
    .rst        (rst),
    .en         (ce),
    .count      (w_h_count),
    .count_next (w_h_next),
    .wrap       (w_h_wrap)
  );

  mod_counter #(.MAX(V_TOTAL - 11'd1)) u_v_cnt (
    .clk        (pixel_clk),
    .rst        (rst),
    .en         (w_v_en),
    .count      (w_v_count),
    .count_next (w_v_next),
    .wrap       (w_v_wrap)
  );

  // vSync depends only on the line number, so it spans whole lines.
  always_comb begin
    w_blank_next = (w_h_next >= H_VISIBLE) || (w_v_next >= V_VISIBLE);
    w_hsync_next = in_window(w_h_next, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next = in_window(w_v_next, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_blank       <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      // w_v_wrap already carries ce and the horizontal wrap.
      r_frame_start <= w_v_wrap;
      if (ce) begin
        r_blank <= w_blank_next;
        r_hsync <= w_hsync_next;
        r_vsync <= w_vsync_next;
      end
    end
  end

  assign hCount      = w_h_count;
  assign vCount      = w_v_count;
  assign blank       = r_blank;
  assign hSync       = r_hsync;
  assign vSync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line timing and a
// tiny-raster instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam logic [10:0] A_HV = 11'd640, A_HFP = 11'd16, A_HS = 11'd96, A_HT = 11'd800;
  localparam logic [10:0] A_VV = 11'd480, A_VFP = 11'd10, A_VS = 11'd2,  A_VT = 11'd525;
  localparam logic [10:0] B_HV = 11'd8,   B_HFP = 11'd2,  B_HS = 11'd3,  B_HBP = 11'd2;
  localparam logic [10:0] B_VV = 11'd4,   B_VFP = 11'd2,  B_VS = 11'd2,  B_VBP = 11'd1;
  localparam logic [10:0] B_HT = 11'd15,  B_VT = 11'd9;

  logic        pixel_clk;
  logic        rst;
  logic        ce;
  logic [10:0] h_a, v_a, h_b, v_b;
  logic        bl_a, hs_a, vs_a, fs_a;
  logic        bl_b, hs_b, vs_b, fs_b;

  logic [10:0] mh_a, mv_a, mh_b, mv_b;
  logic        exp_fs_a, exp_fs_b;

  int n_checks;
  int n_bad;

  vga_timing_gen u_dut_a (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .ce          (ce),
    .hCount      (h_a),
    .vCount      (v_a),
    .blank       (bl_a),
    .hSync       (hs_a),
    .vSync       (vs_a),
    .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (B_HV), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_VISIBLE (B_VV), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
    .SYNC_POL  (1'b0)
  ) u_dut_b (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .ce          (ce),
    .hCount      (h_b),
    .vCount      (v_b),
    .blank       (bl_b),
    .hSync       (hs_b),
    .vSync       (vs_b),
    .frame_start (fs_b)
  );

  // clock / reset
  initial pixel_clk = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // {blank, hSync, vSync} for active-low syncs
  function automatic logic [2:0] ref_flags(input logic [10:0] h, input logic [10:0] v,
                                           input logic [10:0] hv, input logic [10:0] hfp,
                                           input logic [10:0] hs, input logic [10:0] vv,
                                           input logic [10:0] vfp, input logic [10:0] vs);
    logic bl, hsy, vsy;
    bl  = (h >= hv) || (v >= vv);
    hsy = !((h >= hv + hfp) && (h <= hv + hfp + hs - 11'd1));
    vsy = !((v >= vv + vfp) && (v <= vv + vfp + vs - 11'd1));
    return {bl, hsy, vsy};
  endfunction

  // returns {frame_wrap, v, h} after one enabled pixel
  function automatic logic [22:0] advance(input logic [10:0] h, input logic [10:0] v,
                                          input logic [10:0] ht, input logic [10:0] vt);
    logic fw;
    fw = 1'b0;
    if (h == ht - 11'd1) begin
      h = '0;
      if (v == vt - 11'd1) begin
        v  = '0;
        fw = 1'b1;
      end else begin
        v = v + 11'd1;
      end
    end else begin
      h = h + 11'd1;
    end
    return {fw, v, h};
  endfunction

  task automatic reset_model();
    mh_a = '0; mv_a = '0; mh_b = '0; mv_b = '0;
    exp_fs_a = 1'b0; exp_fs_b = 1'b0;
  endtask

  task automatic compare_all();
    logic [2:0] fa, fb;
    fa = ref_flags(mh_a, mv_a, A_HV, A_HFP, A_HS, A_VV, A_VFP, A_VS);
    fb = ref_flags(mh_b, mv_b, B_HV, B_HFP, B_HS, B_VV, B_VFP, B_VS);
    check("a_hcount", h_a, mh_a);
    check("a_vcount", v_a, mv_a);
    check("a_blank",  bl_a, fa[2]);
    check("a_hsync",  hs_a, fa[1]);
    check("a_vsync",  vs_a, fa[0]);
    check("a_fstart", fs_a, exp_fs_a);
    check("b_hcount", h_b, mh_b);
    check("b_vcount", v_b, mv_b);
    check("b_blank",  bl_b, fb[2]);
    check("b_hsync",  hs_b, fb[1]);
    check("b_vsync",  vs_b, fb[0]);
    check("b_fstart", fs_b, exp_fs_b);
  endtask

  // driver: apply ce for one edge, step the model, compare #1 after the edge
  task automatic tick(input logic ce_val);
    logic [22:0] r;
    ce = ce_val;
    @(posedge pixel_clk);
    #1;
    exp_fs_a = 1'b0;
    exp_fs_b = 1'b0;
    if (ce_val) begin
      r = advance(mh_a, mv_a, A_HT, A_VT);
      {exp_fs_a, mv_a, mh_a} = r;
      r = advance(mh_b, mv_b, B_HT, B_VT);
      {exp_fs_b, mv_b, mh_b} = r;
    end
    compare_all();
  endtask

  int hs_low_a, blank_a, fs_cnt_b, vs_low_b, blank_b, first_fs_k;
  int tog_fs_cnt, tog_k1, tog_k2;

  initial begin
    n_checks = 0; n_bad = 0;
    hs_low_a = 0; blank_a = 0; fs_cnt_b = 0; vs_low_b = 0; blank_b = 0; first_fs_k = -1;
    tog_fs_cnt = 0; tog_k1 = -1; tog_k2 = -1;
    rst = 1'b1;
    ce  = 1'b1;
    reset_model();

    // reset values held while rst is high, even with ce=1
    repeat (3) @(posedge pixel_clk);
    #1;
    compare_all();
    check("rst_hsync_a", hs_a, 1);
    check("rst_vsync_a", vs_a, 1);
    check("rst_blank_a", bl_a, 0);
    check("rst_fs_b",    fs_b, 0);

    rst = 1'b0;
    tick(1'b1);
    check("rel_h_a", h_a, 1);
    check("rel_v_a", v_a, 0);
    repeat (99) tick(1'b1);
    check("mid_h_a", h_a, 100);
    check("mid_vs_b", vs_b, 0);

    // asynchronous reset in the middle of a clock period
    #10 rst = 1'b1;
    #1;
    reset_model();
    check("async_h_a",  h_a, 0);
    check("async_v_a",  v_a, 0);
    check("async_h_b",  h_b, 0);
    check("async_v_b",  v_b, 0);
    check("async_vs_b", vs_b, 1);
    check("async_bl_b", bl_b, 0);
    check("async_fs_a", fs_a, 0);
    @(posedge pixel_clk);
    #1;
    compare_all();
    rst = 1'b0;
    tick(1'b1);
    check("rel2_h_a", h_a, 1);
    check("rel2_v_a", v_a, 0);

    // continuous ce: two lines of A, twelve frames of B
    for (int k = 2; k <= 1700; k++) begin
      tick(1'b1);
      if (v_a == 11'd0 && !hs_a) hs_low_a++;
      if (v_a == 11'd0 && bl_a) blank_a++;
      if (k <= 1620) begin
        if (fs_b) fs_cnt_b++;
        if (!vs_b) vs_low_b++;
        if (bl_b) blank_b++;
      end
      if (fs_b && first_fs_k < 0) first_fs_k = k;
      if (k == 639) check("edge639_bl_a", bl_a, 0);
      if (k == 640) check("edge640_bl_a", bl_a, 1);
      if (k == 655) check("edge655_hs_a", hs_a, 1);
      if (k == 656) check("edge656_hs_a", hs_a, 0);
      if (k == 751) check("edge751_hs_a", hs_a, 0);
      if (k == 752) check("edge752_hs_a", hs_a, 1);
      if (k == 799) begin
        check("eol_h_a", h_a, 799);
        check("eol_v_a", v_a, 0);
      end
      if (k == 800) begin
        check("sol_h_a",  h_a, 0);
        check("sol_v_a",  v_a, 1);
        check("sol_bl_a", bl_a, 0);
      end
      if (k == 135) begin
        check("wrap_h_b",  h_b, 0);
        check("wrap_v_b",  v_b, 0);
        check("wrap_bl_b", bl_b, 0);
      end
      if (k == 136) check("wrap_next_fs_b", fs_b, 0);
    end
    check("line_hsync_low_a", hs_low_a, 96);
    check("line_blank_a",     blank_a, 160);
    check("frames_fs_b",      fs_cnt_b, 12);
    check("first_fs_k_b",     first_fs_k, 135);
    check("frames_vs_low_b",  vs_low_b, 360);
    check("frames_blank_b",   blank_b, 1236);

    // alternating ce: counts advance every other edge
    for (int k = 0; k < 540; k++) begin
      tick((k % 2) == 1);
      if (fs_b) begin
        tog_fs_cnt++;
        if (tog_k1 < 0) tog_k1 = k;
        else if (tog_k2 < 0) tog_k2 = k;
      end
    end
    check("tog_fs_cnt_b", tog_fs_cnt, 2);
    check("tog_first_k_b", tog_k1, 109);
    check("tog_period_b", tog_k2 - tog_k1, 270);
    check("tog_h_a", h_a, 370);
    check("tog_v_a", v_a, 2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
